fsm_responder: RTL
==================

Name: fsm_responder

Overview:
- Responder end of the ctl/done sequencing handshake driven by the fsm initiator (IDLE -> GO -> DONE cycle).
- Monitors ctl_i/done_i, checks protocol ordering and timing, pulses ack per completed transaction, counts transactions and latches sticky errors.
- Sits on the consumer side of the initiator, in the same clock domain, with no synchronisers.

Parameters:
- TIMEOUT, 8, max ARMED cycles allowed for done_i after ctl_i sampled; legal range 1..255.
- CNT_W, 8, width of txn_count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  responder enable; 0 aborts an in-flight transaction.
- ctl_i  input  1  initiator control phase (GO).
- done_i  input  1  initiator completion phase (DONE).
- clr_err  input  1  single-cycle pulse that clears sticky error.
- ack  output  1  one-cycle pulse per accepted transaction.
- busy  output  1  high while state == ARMED.
- err  output  1  sticky error flag (state == ERROR).
- err_code  output  2  0 none, 1 ORPHAN_DONE, 2 OVERLAP, 3 TIMEOUT.
- txn_count  output  CNT_W  accepted transactions, saturating.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timer=0, ack=0, busy=0, err=0, err_code=0, txn_count=0. Release is synchronous to the next clk edge.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- States are IDLE, ARMED, COMPLETE, ERROR. Encoding is free; default case goes to IDLE.
- IDLE, evaluated in priority order:
  - en=0: stay.
  - ctl_i & done_i: ERROR, code OVERLAP.
  - done_i: ERROR, code ORPHAN_DONE.
  - ctl_i: ARMED, timer <= TIMEOUT.
  - else: stay.
- ARMED:
  - en=0: IDLE; no count, no error.
  - ctl_i & done_i: ERROR, code OVERLAP.
  - done_i: COMPLETE.
  - timer==1: ERROR, code TIMEOUT.
  - else: timer <= timer-1.
  - ctl_i held high in ARMED is legal and does not reload the timer.
- ARMED timing: done_i is accepted in the TIMEOUT cycles following the ctl_i sample cycle. With TIMEOUT=1, done_i must arrive the cycle after ctl_i.
- COMPLETE lasts exactly one cycle:
  - ack=1.
  - txn_count <= txn_count+1, saturating at 2^CNT_W-1.
  - Next state, in priority order: en=0 -> IDLE; ctl_i & done_i -> ERROR OVERLAP; done_i -> ERROR ORPHAN_DONE; ctl_i -> ARMED, timer <= TIMEOUT (back-to-back); else IDLE.
- ERROR:
  - err=1, err_code holds the code captured on entry; first error wins.
  - ctl_i, done_i and en are ignored.
  - clr_err=1 -> IDLE, err_code <= 0.
  - clr_err outside ERROR has no effect.
- Latency:
  - ack asserts the cycle after done_i is sampled in ARMED.
  - err asserts the cycle after the offending sample.
  - busy asserts the cycle after ctl_i is sampled.
- Nominal initiator sequence is ctl 1 cycle, done the next cycle, 1 idle cycle, repeat. This yields ack once every 3 cycles, with no error for any TIMEOUT >= 1.
- Reset mid-transaction: everything returns to reset values immediately; txn_count is lost.

Test Plan:
- Nominal: reset, then 4 initiator cycles (ctl@t, done@t+1, idle@t+2) -> ack at t+2 each time, busy at t+1, txn_count=4, err=0.
- Timeout: TIMEOUT=3, ctl pulse at t, no done -> busy t+1..t+3, err=1 and err_code=3 at t+4. A later done is ignored. clr_err -> IDLE, err_code=0, txn_count unchanged.
- Protocol errors:
  - done_i alone in IDLE -> err_code=1.
  - After clr_err, ctl_i & done_i together -> err_code=2.
  - Error plus a second violation while in ERROR -> code unchanged (first wins).
- Back-to-back and hold: ctl held 3 cycles then done -> single ack, count +1. ctl high in the COMPLETE cycle -> ARMED directly, second ack with no IDLE cycle.
- Enable and saturation:
  - en=0 while ARMED -> IDLE, no ack, no err.
  - CNT_W=2 with 5 transactions -> txn_count sticks at 3.
  - rst_n low mid-ARMED -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fsm_responder.sv
// Responder for the ctl/done sequencing handshake: checks ordering and timing,
// pulses ack per accepted transaction, counts them and latches the first error.
module fsm_responder #(
   parameter int unsigned TIMEOUT = 8,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             ctl_i,
   input  logic             done_i,
   input  logic             clr_err,
   output logic             ack,
   output logic             busy,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] txn_count
);

   localparam int unsigned TMR_W = 8;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

   localparam logic [1:0] CODE_NONE    = 2'd0;
   localparam logic [1:0] CODE_ORPHAN  = 2'd1;
   localparam logic [1:0] CODE_OVERLAP = 2'd2;
   localparam logic [1:0] CODE_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_COMPLETE = 2'd2,
      S_ERROR    = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [1:0]         code_q, code_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   // Next-state, timer, error capture and counter update
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      code_d  = code_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (en) begin
               if (ctl_i && done_i) begin
                  state_d = S_ERROR;
                  code_d  = CODE_OVERLAP;
               end else if (done_i) begin
                  state_d = S_ERROR;
                  code_d  = CODE_ORPHAN;
               end else if (ctl_i) begin
                  state_d = S_ARMED;
                  timer_d = TMR_LOAD;
               end
            end
         end

         S_ARMED: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (ctl_i && done_i) begin
               state_d = S_ERROR;
               code_d  = CODE_OVERLAP;
            end else if (done_i) begin
               state_d = S_COMPLETE;
            end else if (timer_q == TMR_W'(1)) begin
               state_d = S_ERROR;
               code_d  = CODE_TIMEOUT;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end

         S_COMPLETE: begin
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (!en) begin
               state_d = S_IDLE;
            end else if (ctl_i && done_i) begin
               state_d = S_ERROR;
               code_d  = CODE_OVERLAP;
            end else if (done_i) begin
               state_d = S_ERROR;
               code_d  = CODE_ORPHAN;
            end else if (ctl_i) begin
               state_d = S_ARMED;
               timer_d = TMR_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ERROR: begin
            // Inputs other than clr_err are ignored so the first code sticks
            if (clr_err) begin
               state_d = S_IDLE;
               code_d  = CODE_NONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Flag outputs registered from the next state so they track state_q exactly
   always_comb begin
      ack_d  = (state_d == S_COMPLETE);
      busy_d = (state_d == S_ARMED);
      err_d  = (state_d == S_ERROR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         code_q  <= CODE_NONE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign ack       = ack_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign err_code  = code_q;
   assign txn_count = cnt_q;

endmodule
